des_block_sequencer: RTL and testbench

// - Sequences the 16-round iterative DES core over a range of 64-bit blocks held in the input block RAM.
// - Writes each result to the output block RAM and supports ECB and CBC chaining.
// - Sits between the host-loaded RAMs (PipeIn/PipeOut side on okClk) and the des core on dcm_clk.
// - Replaces the ad-hoc block loop in the toplevel with programmable base addresses and block count.

---
 rtl/des_seq_pkg.sv | 18 +
 rtl/des_cbc_chain.sv | 54 +++++
 rtl/des_block_sequencer.sv | 136 +++++++++++++
 tb/tb_des_block_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_seq_pkg.sv
// Shared constants and FSM state encoding for the DES block sequencer.
package des_seq_pkg;

    localparam int DES_ROUNDS      = 16;
    localparam int WORDS_PER_BLOCK = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD0   = 3'd1,
        S_RD1   = 3'd2,
        S_RD2   = 3'd3,
        S_ROUND = 3'd4,
        S_WR_LO = 3'd5,
        S_WR_HI = 3'd6,
        S_DONE  = 3'd7
    } state_t;

endpackage

// File: rtl/des_cbc_chain.sv
// Block assembly and CBC chaining around the DES core: builds the 64-bit
// block from two RAM words, applies the encrypt-side input XOR, captures the
// core result with the decrypt-side output XOR, and advances the chain value.
module des_cbc_chain
    import des_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,      // operation accepted: chain <= iv
    input  logic [63:0] iv,
    input  logic        cbc,
    input  logic        dec,
    input  logic        lo_en,     // low word on rdata
    input  logic        hi_en,     // high word on rdata; block complete
    input  logic [31:0] rdata,
    input  logic        cap_en,    // last round: core result valid
    input  logic [63:0] des_out,
    output logic [63:0] des_in,
    output logic [63:0] res
);

    logic [31:0] blk_lo;
    logic [63:0] blk;
    logic [63:0] chain;
    logic [63:0] blk_next;

    assign blk_next = {rdata, blk_lo};

    // Block capture, core input load, result capture and chain update.
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_lo <= '0;
            blk    <= '0;
            chain  <= '0;
            des_in <= '0;
            res    <= '0;
        end else begin
            if (init)
                chain <= iv;
            if (lo_en)
                blk_lo <= rdata;
            if (hi_en) begin
                blk    <= blk_next;
                des_in <= (cbc && !dec) ? (blk_next ^ chain) : blk_next;
            end
            if (cap_en) begin
                res   <= (cbc && dec) ? (des_out ^ chain) : des_out;
                // Encrypt chains on ciphertext out, decrypt on ciphertext in.
                chain <= dec ? blk : des_out;
            end
        end
    end

endmodule

// File: rtl/des_block_sequencer.sv
// Walks a range of 64-bit blocks through the iterative DES core: two-word
// read, 16 rounds, two-word write, repeated for the programmed block count.
module des_block_sequencer
    import des_seq_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 8
) (
    input  logic              dcm_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              decrypt,
    input  logic              cbc_en,
    input  logic [63:0]       iv,
    input  logic [CNT_W-1:0]  num_blocks,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_rdata,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_we,
    output logic [31:0]       out_wdata,
    output logic [63:0]       des_in,
    output logic [3:0]        des_round_sel,
    output logic              des_decrypt,
    input  logic [63:0]       des_out,
    output logic              busy,
    output logic              done,
    output logic [CNT_W:0]    blocks_done
);

    state_t       state, state_nxt;
    logic [3:0]   rnd;
    logic         cbc_q;
    logic [CNT_W:0] target;
    logic [CNT_W:0] blocks_inc;
    logic         last_round;
    logic         accept;
    logic [63:0]  res;

    assign blocks_inc = blocks_done + 1'b1;
    assign last_round = (rnd == 4'(DES_ROUNDS - 1));
    assign accept     = (state == S_IDLE) && start;

    // State register.
    always_ff @(posedge dcm_clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nxt     = state;
        busy          = 1'b0;
        done          = 1'b0;
        out_we        = 1'b0;
        out_wdata     = '0;
        des_round_sel = '0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RD0;
            S_RD0:   begin busy = 1'b1; state_nxt = S_RD1; end
            S_RD1:   begin busy = 1'b1; state_nxt = S_RD2; end
            S_RD2:   begin busy = 1'b1; state_nxt = S_ROUND; end
            S_ROUND: begin
                busy          = 1'b1;
                des_round_sel = rnd;
                if (last_round) state_nxt = S_WR_LO;
            end
            S_WR_LO: begin
                busy      = 1'b1;
                out_we    = 1'b1;
                out_wdata = res[31:0];
                state_nxt = S_WR_HI;
            end
            S_WR_HI: begin
                busy      = 1'b1;
                out_we    = 1'b1;
                out_wdata = res[63:32];
                state_nxt = (blocks_inc == target) ? S_DONE : S_RD0;
            end
            S_DONE:  begin done = 1'b1; state_nxt = S_IDLE; end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Configuration latch, address counters, round and block counters.
    always_ff @(posedge dcm_clk) begin
        if (reset) begin
            in_addr     <= '0;
            out_addr    <= '0;
            rnd         <= '0;
            blocks_done <= '0;
            target      <= '0;
            des_decrypt <= 1'b0;
            cbc_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    des_decrypt <= decrypt;
                    cbc_q       <= cbc_en;
                    // A zero count means the full 2**CNT_W range.
                    target      <= {(num_blocks == '0), num_blocks};
                    in_addr     <= in_base;
                    out_addr    <= out_base;
                    blocks_done <= '0;
                end
                S_RD0, S_RD1: in_addr <= in_addr + 1'b1;
                S_RD2:   rnd <= '0;
                S_ROUND: rnd <= rnd + 1'b1;
                S_WR_LO: out_addr <= out_addr + 1'b1;
                S_WR_HI: begin
                    out_addr    <= out_addr + 1'b1;
                    blocks_done <= blocks_inc;
                end
                default: ;
            endcase
        end
    end

    des_cbc_chain u_chain (
        .clk     (dcm_clk),
        .reset   (reset),
        .init    (accept),
        .iv      (iv),
        .cbc     (cbc_q),
        .dec     (des_decrypt),
        .lo_en   (state == S_RD1),
        .hi_en   (state == S_RD2),
        .rdata   (in_rdata),
        .cap_en  ((state == S_ROUND) && last_round),
        .des_out (des_out),
        .des_in  (des_in),
        .res     (res)
    );

endmodule

// File: tb/tb_des_block_sequencer.sv
// Bench for des_block_sequencer: behavioural DES core, two RAM models and a
// block-level ECB/CBC reference model checked against the written output RAM.
module tb_des_block_sequencer;

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

    localparam int IP [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    localparam int FP [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
    localparam int EX [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                               16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    localparam int PP [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    localparam int PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    localparam int PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int SB [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    // Plain single-block DES (FIPS 46) used both as the core and in the reference model.
    function automatic logic [63:0] des_fn(input logic [63:0] data, input logic [63:0] key, input logic dec);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [63:0] t, o;
        logic [31:0] l, r, f0, f, nr;
        logic [47:0] e, x;
        logic [5:0]  six;
        int          v;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int k = 0; k < 16; k++) begin
            for (int s = 0; s < SHIFTS[k]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[k][47-i] = cd[56-PC2[i]];
        end
        for (int i = 0; i < 64; i++) t[63-i] = data[64-IP[i]];
        l = t[63:32];
        r = t[31:0];
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 48; i++) e[47-i] = r[32-EX[i]];
            x = e ^ (dec ? ks[15-k] : ks[k]);
            for (int s = 0; s < 8; s++) begin
                six = x[47-6*s -: 6];
                v = SB[s][int'(six[5])*32 + int'(six[0])*16 + int'(six[4:1])];
                f0[31-4*s -: 4] = v[3:0];
            end
            for (int i = 0; i < 32; i++) f[31-i] = f0[32-PP[i]];
            nr = l ^ f;
            l  = r;
            r  = nr;
        end
        t = {r, l};
        for (int i = 0; i < 64; i++) o[63-i] = t[64-FP[i]];
        return o;
    endfunction

    logic        dcm_clk = 1'b0;
    logic        reset, start, decrypt, cbc_en;
    logic [63:0] iv;
    logic [7:0]  num_blocks;
    logic [8:0]  in_base, out_base, in_addr, out_addr;
    logic [31:0] in_rdata, out_wdata;
    logic        out_we, des_decrypt, busy, done;
    logic [63:0] des_in, des_out;
    logic [3:0]  des_round_sel;
    logic [8:0]  blocks_done;

    logic [31:0] in_ram  [512];
    logic [31:0] out_ram [512];
    logic [63:0] din_log [1024];
    logic [31:0] r15_cnt = 0;
    int          wr_cnt = 0, done_cnt = 0, dec_bad = 0;
    logic [8:0]  last_waddr = '0;
    logic        exp_dec;
    int          checks = 0, errors = 0;

    always #5 dcm_clk = ~dcm_clk;

    des_block_sequencer #(.ADDR_W(9), .CNT_W(8)) dut (
        .dcm_clk(dcm_clk), .reset(reset), .start(start), .decrypt(decrypt), .cbc_en(cbc_en),
        .iv(iv), .num_blocks(num_blocks), .in_base(in_base), .out_base(out_base),
        .in_addr(in_addr), .in_rdata(in_rdata), .out_addr(out_addr), .out_we(out_we),
        .out_wdata(out_wdata), .des_in(des_in), .des_round_sel(des_round_sel),
        .des_decrypt(des_decrypt), .des_out(des_out), .busy(busy), .done(done),
        .blocks_done(blocks_done)
    );

    // Core model: result only presented in the last round.
    assign des_out = (des_round_sel == 4'd15) ? des_fn(des_in, KEY, des_decrypt) : 64'h0;

    // RAM models and activity monitors.
    always @(posedge dcm_clk) begin
        in_rdata <= in_ram[in_addr];
        if (out_we) begin
            out_ram[out_addr] <= out_wdata;
            wr_cnt            <= wr_cnt + 1;
            last_waddr        <= out_addr;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (busy && des_decrypt !== exp_dec) dec_bad <= dec_bad + 1;
        if (des_round_sel == 4'd15) begin
            din_log[r15_cnt[9:0]] <= des_in;
            r15_cnt               <= r15_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic dec, input logic cbc, input logic [63:0] ivv,
                            input int n, input logic [8:0] ib, input logic [8:0] ob);
        @(negedge dcm_clk);
        exp_dec = dec; decrypt = dec; cbc_en = cbc; iv = ivv;
        num_blocks = 8'(n); in_base = ib; out_base = ob; start = 1'b1;
        @(negedge dcm_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int from, input int limit, output int cyc);
        cyc = from;
        while (done !== 1'b1 && cyc < limit) begin
            @(negedge dcm_clk);
            cyc++;
        end
    endtask

    // Block-level reference: ECB/CBC over the input RAM, compared word by word.
    task automatic check_results(input string tag, input logic dec, input logic cbc, input logic [63:0] ivv,
                                 input int n, input logic [8:0] ib, input logic [8:0] ob);
        logic [63:0] chain, blk, o;
        logic [8:0]  a;
        chain = ivv;
        for (int k = 0; k < n; k++) begin
            a   = ib + 9'(2*k);
            blk = {in_ram[a + 9'd1], in_ram[a]};
            if (!dec) begin
                o     = des_fn(cbc ? (blk ^ chain) : blk, KEY, 1'b0);
                chain = o;
            end else begin
                o = des_fn(blk, KEY, 1'b1);
                if (cbc) o = o ^ chain;
                chain = blk;
            end
            a = ob + 9'(2*k);
            check({tag, "_lo"}, 64'(out_ram[a]), 64'(o[31:0]));
            check({tag, "_hi"}, 64'(out_ram[a + 9'd1]), 64'(o[63:32]));
        end
    endtask

    task automatic do_op(input string tag, input logic dec, input logic cbc, input logic [63:0] ivv,
                         input int n, input logic [8:0] ib, input logic [8:0] ob);
        int cyc, wr0, db0;
        wr0 = wr_cnt; db0 = dec_bad;
        start_op(dec, cbc, ivv, n, ib, ob);
        check({tag, "_busy"}, 64'(busy), 64'(1));
        wait_done(1, 21*n + 40, cyc);
        check({tag, "_latency"}, 64'(cyc), 64'(21*n + 1));
        @(negedge dcm_clk);
        check({tag, "_done_pulse"}, 64'(done), 64'(0));
        check({tag, "_busy_after"}, 64'(busy), 64'(0));
        check({tag, "_blocks_done"}, 64'(blocks_done), 64'(n));
        check({tag, "_writes"}, 64'(wr_cnt - wr0), 64'(2*n));
        check({tag, "_dec_held"}, 64'(dec_bad - db0), 64'(0));
        check_results(tag, dec, cbc, ivv, n, ib, ob);
    endtask

    initial begin
        int          cyc, wr0, dn0, db0;
        logic [31:0] rn0;
        logic [63:0] civ;
        reset = 1'b1; start = 1'b0; decrypt = 1'b0; cbc_en = 1'b0; iv = '0;
        num_blocks = '0; in_base = '0; out_base = '0; exp_dec = 1'b0;
        for (int i = 0; i < 512; i++) in_ram[i] = $urandom;
        in_ram[0] = 32'h89ABCDEF; in_ram[1] = 32'h01234567;
        in_ram[2] = 32'h0F0AB405; in_ram[3] = 32'h85E81354;
        repeat (3) @(negedge dcm_clk);
        reset = 1'b0;
        @(negedge dcm_clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_we", 64'(out_we), 64'(0));
        check("rst_addrs", 64'({in_addr, out_addr, des_round_sel, des_decrypt}), 64'(0));
        check("rst_blocks", 64'(blocks_done), 64'(0));
        check("rst_data", des_in ^ 64'(out_wdata), 64'(0));

        // Known-answer ECB encrypt and decrypt.
        do_op("ecb_enc", 1'b0, 1'b0, {$urandom, $urandom}, 1, 9'h000, 9'h000);
        check("kat_ct_lo", 64'(out_ram[0]), 64'h0F0AB405);
        check("kat_ct_hi", 64'(out_ram[1]), 64'h85E81354);
        do_op("ecb_dec", 1'b1, 1'b0, {$urandom, $urandom}, 1, 9'h002, 9'h004);
        check("kat_pt_lo", 64'(out_ram[4]), 64'h89ABCDEF);
        check("kat_pt_hi", 64'(out_ram[5]), 64'h01234567);

        // CBC round trip.
        civ = 64'hFEDCBA9876543210;
        rn0 = r15_cnt;
        do_op("cbc_enc", 1'b0, 1'b1, civ, 4, 9'h010, 9'h040);
        check("cbc_des_in0", din_log[rn0[9:0]], {in_ram[9'h011], in_ram[9'h010]} ^ civ);
        for (int i = 0; i < 8; i++) in_ram[9'h080 + 9'(i)] = out_ram[9'h040 + 9'(i)];
        do_op("cbc_dec", 1'b1, 1'b1, civ, 4, 9'h080, 9'h0C0);
        for (int i = 0; i < 8; i++)
            check("cbc_roundtrip", 64'(out_ram[9'h0C0 + 9'(i)]), 64'(in_ram[9'h010 + 9'(i)]));

        // Randomized modes, counts and (possibly wrapping) bases.
        for (int t = 0; t < 4; t++)
            do_op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
                  $urandom_range(1, 6), 9'($urandom), 9'($urandom));

        // Start while busy is ignored.
        wr0 = wr_cnt; db0 = dec_bad;
        start_op(1'b0, 1'b0, 64'h0, 2, 9'h020, 9'h060);
        cyc = 1;
        while (cyc < 10) begin @(negedge dcm_clk); cyc++; end
        decrypt = 1'b1; cbc_en = 1'b1; num_blocks = 8'd9; in_base = 9'h1A0; out_base = 9'h100; start = 1'b1;
        @(negedge dcm_clk);
        start = 1'b0;
        wait_done(11, 80, cyc);
        check("busy_start_latency", 64'(cyc), 64'(43));
        @(negedge dcm_clk);
        check("busy_start_blocks", 64'(blocks_done), 64'(2));
        check("busy_start_writes", 64'(wr_cnt - wr0), 64'(4));
        check("busy_start_last_addr", 64'(last_waddr), 64'(9'h063));
        check("busy_start_dec", 64'(dec_bad - db0), 64'(0));
        check_results("busy_start", 1'b0, 1'b0, 64'h0, 2, 9'h020, 9'h060);

        // Start coincident with reset.
        @(negedge dcm_clk);
        in_base = 9'h055; decrypt = 1'b1; num_blocks = 8'd3; reset = 1'b1; start = 1'b1;
        @(negedge dcm_clk);
        reset = 1'b0; start = 1'b0;
        check("rst_start_busy", 64'(busy), 64'(0));
        repeat (3) @(negedge dcm_clk);
        check("rst_start_idle", 64'({busy, des_decrypt, in_addr}), 64'(0));
        check("rst_start_blocks", 64'(blocks_done), 64'(0));

        // Reset during the rounds of the third block of five.
        wr0 = wr_cnt; dn0 = done_cnt;
        start_op(1'b0, 1'b1, {$urandom, $urandom}, 5, 9'h030, 9'h070);
        cyc = 1;
        while (cyc < 51) begin @(negedge dcm_clk); cyc++; end
        check("mid_round_sel", 64'(des_round_sel), 64'(5));
        reset = 1'b1;
        @(negedge dcm_clk);
        reset = 1'b0;
        check("mid_rst_we", 64'(out_we), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_blocks", 64'(blocks_done), 64'(0));
        repeat (40) @(negedge dcm_clk);
        check("mid_rst_writes", 64'(wr_cnt - wr0), 64'(4));
        check("mid_rst_no_done", 64'(done_cnt - dn0), 64'(0));
        do_op("after_rst", 1'b1, 1'b1, {$urandom, $urandom}, 3, 9'h1FE, 9'h0F0);

        // Zero count: full 256 blocks with both address ranges wrapping.
        do_op("wrap256", 1'b0, 1'b1, {$urandom, $urandom}, 256, 9'h1F0, 9'h1F0);
        check("wrap256_last_addr", 64'(last_waddr), 64'(9'h1EF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
